vid_mem_target: RTL

Bus target (responder) for the video-subsystem request/response bus: accepts single and burst read/write requests from initiators such as the video fetch engine, stores write data in an internal word-addressed frame/line memory, and returns read data and write acknowledgements as bus responses. It sits on the shared bus opposite the video initiators and arbitrates for the bus through the same `reqout`/grant mechanism when it has a response to send.

---
 rtl/vid_bus_pkg.sv | 26 ++
 rtl/vid_mem_target_if.sv | 26 ++
 rtl/vid_tgt_ram.sv | 21 ++
 rtl/vid_mem_target.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vid_bus_pkg.sv
// rtl/vid_bus_pkg.sv - video bus command codes, burst length decode and target state encoding
package vid_bus_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE       = 3'b000,
        CMD_READ       = 3'b010,
        CMD_READ_RESP  = 3'b011,
        CMD_WRITE      = 3'b100,
        CMD_WRITE_RESP = 3'b101,
        CMD_ERR_RESP   = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RESP_REQ,
        ST_RESP_HDR,
        ST_RESP_DATA
    } tgt_state_e;

    // Length code 00/01/10/11 selects 1/2/4/8 words.
    function automatic logic [3:0] len_words(input logic [1:0] code);
        return 4'd1 << code;
    endfunction

endpackage

// File: rtl/vid_mem_target_if.sv
// rtl/vid_mem_target_if.sv - request/response bus between video initiators and the memory target
interface vid_mem_target_if;
    logic        selin;
    logic [2:0]  cmdin;
    logic [1:0]  lenin;
    logic [3:0]  srcin;
    logic [31:0] addrdatain;
    logic        gntin;
    logic        ackout;
    logic [1:0]  reqout;
    logic [2:0]  cmdout;
    logic [1:0]  lenout;
    logic [3:0]  reqtar;
    logic [31:0] addrdataout;
    logic        busy;

    modport master (
        output selin, cmdin, lenin, srcin, addrdatain, gntin,
        input  ackout, reqout, cmdout, lenout, reqtar, addrdataout, busy
    );

    modport slave (
        input  selin, cmdin, lenin, srcin, addrdatain, gntin,
        output ackout, reqout, cmdout, lenout, reqtar, addrdataout, busy
    );
endinterface

// File: rtl/vid_tgt_ram.sv
// rtl/vid_tgt_ram.sv - single-port synchronous word RAM, read-first, one access per cycle
module vid_tgt_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    // Registered read of the addressed word; optional write of the same word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/vid_mem_target.sv
// rtl/vid_mem_target.sv - video bus memory target; VID_MEM_TARGET_ERR_EN enables address range errors
module vid_mem_target
    import vid_bus_pkg::*;
#(
    parameter int         DEPTH = 256,
    parameter logic [1:0] PRIO  = 2'b10
) (
    input logic            clk,
    input logic            reset,
    vid_mem_target_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    tgt_state_e    state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [31:0]   addr_q;
    logic [1:0]    len_q;
    logic [3:0]    src_q;
    logic          is_rd_q, err_q;
    logic          accept, req_err;
    logic [AW-1:0] idx, ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [3:0]    n_words;

    logic          ack_q, ack_n;
    logic [1:0]    req_q, req_n;
    logic [2:0]    cmd_q, cmd_n;
    logic [1:0]    leno_q, leno_n;
    logic [3:0]    tar_q, tar_n;
    logic [31:0]   ad_q, ad_n;
    logic          busy_q, busy_n;

    assign idx     = addr_q[AW+1:2];
    assign n_words = len_words(len_q);
    assign accept  = (state == ST_IDLE) && bus.selin &&
                     (bus.cmdin == CMD_READ || bus.cmdin == CMD_WRITE);

`ifdef VID_MEM_TARGET_ERR_EN
    // Out of range: address bits above the word index, or burst running past the top word.
    assign req_err = (bus.addrdatain[31:AW+2] != '0) ||
                     (({1'b0, bus.addrdatain[AW+1:2]} + (AW+1)'(len_words(bus.lenin))) >
                      (AW+1)'(DEPTH));
`else
    assign req_err = 1'b0;
`endif

    vid_tgt_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State, beat counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ack_q  <= 1'b0;
            req_q  <= '0;
            cmd_q  <= '0;
            leno_q <= '0;
            tar_q  <= '0;
            ad_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ack_q  <= ack_n;
            req_q  <= req_n;
            cmd_q  <= cmd_n;
            leno_q <= leno_n;
            tar_q  <= tar_n;
            ad_q   <= ad_n;
            busy_q <= busy_n;
        end
    end

    // Request attributes captured on the accepting cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.addrdatain;
            len_q   <= bus.lenin;
            src_q   <= bus.srcin;
            is_rd_q <= (bus.cmdin == CMD_READ);
            err_q   <= req_err;
        end
    end

    // Next state and next output values. The RAM address runs one word ahead of the
    // beat being presented, so word 0 is read while waiting for grant and word k+1
    // while word k is on the bus.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ram_we    = 1'b0;
        ram_addr  = idx + AW'(cnt);
        ram_wdata = bus.addrdatain;
        ack_n     = 1'b0;
        cmd_n     = CMD_IDLE;
        leno_n    = '0;
        tar_n     = '0;
        ad_n      = '0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    ack_n   = 1'b1;
                    state_n = (bus.cmdin == CMD_READ) ? ST_RESP_REQ : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (bus.selin) begin
                    ram_we = !err_q;
                    cnt_n  = cnt + 4'd1;
                    if (cnt == n_words - 4'd1) begin
                        state_n = ST_RESP_REQ;
                        cnt_n   = '0;
                    end
                end
            end
            ST_RESP_REQ: begin
                if (bus.gntin) begin
                    state_n = ST_RESP_HDR;
                    cnt_n   = 4'd1;
                    cmd_n   = err_q ? CMD_ERR_RESP : (is_rd_q ? CMD_READ_RESP : CMD_WRITE_RESP);
                    leno_n  = len_q;
                    tar_n   = src_q;
                    ad_n    = addr_q;
                end
            end
            ST_RESP_HDR: begin
                if (is_rd_q && !err_q) begin
                    state_n = ST_RESP_DATA;
                    cnt_n   = cnt + 4'd1;
                    cmd_n   = CMD_READ_RESP;
                    leno_n  = len_q;
                    tar_n   = src_q;
                    ad_n    = ram_rdata;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RESP_DATA: begin
                cnt_n = cnt + 4'd1;
                if (cnt == n_words + 4'd1) begin
                    state_n = ST_IDLE;
                end else begin
                    cmd_n  = CMD_READ_RESP;
                    leno_n = len_q;
                    tar_n  = src_q;
                    ad_n   = ram_rdata;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        req_n  = (state_n == ST_RESP_REQ) ? PRIO : 2'b00;
        busy_n = (state_n != ST_IDLE);
    end

    assign bus.ackout      = ack_q;
    assign bus.reqout      = req_q;
    assign bus.cmdout      = cmd_q;
    assign bus.lenout      = leno_q;
    assign bus.reqtar      = tar_q;
    assign bus.addrdataout = ad_q;
    assign bus.busy        = busy_q;
endmodule
